// File: rtl/keypad_pkg.sv
// Shared constants and encodings for the 4x4 keypad scanner.
// Used by keypad_scan_debounce and keypad_debounce_fsm.
package keypad_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam logic [3:0] COL_RESET = 4'b1110;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CONFIRM,
    HELD,
    RELEASE_CONFIRM
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } raw_e;

  function automatic logic [2:0] zero_count(
    input logic [NUM_ROWS-1:0] r
  );
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      n = n + {2'b00, ~r[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/keypad_debounce_fsm.sv
// Frame-end debounce FSM with registered press/release/multi pulses.
// Ports: clk, rst_n, frame_end_i, cls_i, code_i -> key_*_o, multi_key_o.
module keypad_debounce_fsm
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_end_i,
  input  raw_e       cls_i,
  input  logic [3:0] code_i,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_held_o,
  output logic       key_release_o,
  output logic       multi_key_o
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_FRAMES);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [3:0]    cand_q;
  logic [3:0]    code_q;
  logic          valid_q;
  logic          held_q;
  logic          rel_q;
  logic          multi_q;

  assign cnt_d = (cnt_q == CMAX) ? CMAX
                                 : cnt_q + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      rel_q   <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      rel_q   <= 1'b0;
      multi_q <= frame_end_i && (cls_i == MULTI);
      if (frame_end_i) begin
        unique case (state_q)
          IDLE: begin
            if (cls_i == SINGLE) begin
              if (DEBOUNCE_FRAMES == 1) begin
                code_q  <= code_i;
                valid_q <= 1'b1;
                held_q  <= 1'b1;
                cnt_q   <= '0;
                state_q <= HELD;
              end else begin
                cand_q  <= code_i;
                cnt_q   <= CW'(1);
                state_q <= PRESS_CONFIRM;
              end
            end
          end
          PRESS_CONFIRM: begin
            if (cls_i == SINGLE && code_i == cand_q) begin
              if (cnt_d == CMAX) begin
                code_q  <= cand_q;
                valid_q <= 1'b1;
                held_q  <= 1'b1;
                cnt_q   <= '0;
                state_q <= HELD;
              end else begin
                cnt_q <= cnt_d;
              end
            end else if (cls_i == SINGLE) begin
              cand_q <= code_i;
              cnt_q  <= CW'(1);
            end else begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end
          end
          HELD: begin
            // A different single key is ignored until release.
            if (cls_i == NONE) begin
              if (DEBOUNCE_FRAMES == 1) begin
                held_q  <= 1'b0;
                rel_q   <= 1'b1;
                cnt_q   <= '0;
                state_q <= IDLE;
              end else begin
                cnt_q   <= CW'(1);
                state_q <= RELEASE_CONFIRM;
              end
            end
          end
          RELEASE_CONFIRM: begin
            if (cls_i == NONE) begin
              if (cnt_d == CMAX) begin
                held_q  <= 1'b0;
                rel_q   <= 1'b1;
                cnt_q   <= '0;
                state_q <= IDLE;
              end else begin
                cnt_q <= cnt_d;
              end
            end else begin
              cnt_q   <= '0;
              state_q <= HELD;
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign key_code_o    = code_q;
  assign key_valid_o   = valid_q;
  assign key_held_o    = held_q;
  assign key_release_o = rel_q;
  assign multi_key_o   = multi_q;

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad column scanner, row synchronizer and frame classifier.
// Ports: clk, rst_n, row -> col, key_code, key_valid/held/release, multi_key.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_held,
  output logic                key_release,
  output logic                multi_key
);

  localparam int DW = $clog2(SCAN_DIV);

  logic [DW-1:0]       div_q;
  logic [DW-1:0]       div_d;
  logic [1:0]          idx_q;
  logic [1:0]          idx_d;
  logic [NUM_ROWS-1:0] sync1_q;
  logic [NUM_ROWS-1:0] sync2_q;
  logic [1:0]          acc_n_q;
  logic [1:0]          acc_n_d;
  logic [3:0]          acc_code_q;
  logic [3:0]          acc_code_d;

  logic       col_end;
  logic       frame_end;
  logic [2:0] zc;
  logic [2:0] sum;
  logic [1:0] rix;
  logic [1:0] mrg_n;
  logic [3:0] mrg_code;
  raw_e       cls;

  assign col_end   = (div_q == DW'(SCAN_DIV - 1));
  assign frame_end = col_end && (idx_q == 2'd3);

  always_comb begin
    rix = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!sync2_q[i]) rix = 2'(i);
    end
  end

  // acc_n counts zeros seen so far this frame,
  // saturating at 2 ("more than one").
  assign zc       = zero_count(sync2_q);
  assign sum      = {1'b0, acc_n_q} + zc;
  assign mrg_n    = (sum >= 3'd2) ? 2'd2 : sum[1:0];
  assign mrg_code = (acc_n_q == 2'd0) ? {idx_q, rix}
                                      : acc_code_q;

  always_comb begin
    cls = NONE;
    unique case (1'b1)
      (mrg_n == 2'd0): cls = NONE;
      (mrg_n == 2'd1): cls = SINGLE;
      default:         cls = MULTI;
    endcase
  end

  always_comb begin
    div_d      = div_q + DW'(1);
    idx_d      = idx_q;
    acc_n_d    = acc_n_q;
    acc_code_d = acc_code_q;
    if (col_end) begin
      div_d      = '0;
      idx_d      = idx_q + 2'd1;
      acc_n_d    = mrg_n;
      acc_code_d = mrg_code;
    end
    if (frame_end) begin
      acc_n_d    = 2'd0;
      acc_code_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      idx_q      <= 2'd0;
      sync1_q    <= '1;
      sync2_q    <= '1;
      acc_n_q    <= 2'd0;
      acc_code_q <= 4'd0;
    end else begin
      div_q      <= div_d;
      idx_q      <= idx_d;
      sync1_q    <= row;
      sync2_q    <= sync1_q;
      acc_n_q    <= acc_n_d;
      acc_code_q <= acc_code_d;
    end
  end

  assign col = ~(4'b0001 << idx_q);

  keypad_debounce_fsm #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_end_i  (frame_end),
    .cls_i        (cls),
    .code_i       (mrg_code),
    .key_code_o   (key_code),
    .key_valid_o  (key_valid),
    .key_held_o   (key_held),
    .key_release_o(key_release),
    .multi_key_o  (multi_key)
  );

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce (SCAN_DIV=8, 3 frames).
// Models the key matrix and checks scan, debounce and reset.
module tb_keypad_scan_debounce;

  logic       clk;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       key_release;
  logic       multi_key;
  logic [15:0] keys;

  int nvec;
  int nerr;

  keypad_scan_debounce #(
    .SCAN_DIV(8),
    .DEBOUNCE_FRAMES(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .row        (row),
    .col        (col),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held),
    .key_release(key_release),
    .multi_key  (multi_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4+r] && !col[c]) row[r] = 1'b0;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] k);
    rst_n = 1'b0;
    keys  = k;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [3:0] exp_col [4];
    exp_col[0] = 4'b1101;
    exp_col[1] = 4'b1011;
    exp_col[2] = 4'b0111;
    exp_col[3] = 4'b1110;
    keys  = '0;
    rst_n = 1'b0;
    tick(2);
    nvec++;
    if (col !== 4'b1110) begin
      nerr++;
      $display("FAIL reset_col: got %b want 1110", col);
    end
    nvec++;
    if (key_code !== 4'd0) begin
      nerr++;
      $display("FAIL reset_code: got %0d want 0", key_code);
    end
    nvec++;
    if ({key_valid, key_held, key_release, multi_key} !== 4'b0) begin
      nerr++;
      $display("FAIL reset_flags: got %b want 0000",
               {key_valid, key_held, key_release, multi_key});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(7);
    nvec++;
    if (col !== 4'b1110) begin
      nerr++;
      $display("FAIL scan_c7: got %b want 1110", col);
    end
    tick(1);
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (col !== exp_col[i]) begin
        nerr++;
        $display("FAIL scan_%0d: got %b want %b",
                 i, col, exp_col[i]);
      end
      if (i < 3) tick(8);
    end
  endtask

  task automatic test_single_press;
    int nv;
    int nh;
    do_reset(16'h0200);
    nv = 0;
    for (int i = 0; i < 95; i++) begin
      tick(1);
      if (key_valid) nv++;
    end
    nvec++;
    if (nv !== 0) begin
      nerr++;
      $display("FAIL press_early: got %0d pulses want 0", nv);
    end
    tick(1);
    nvec++;
    if ({key_valid, key_held, key_code} !== {2'b11, 4'd9}) begin
      nerr++;
      $display("FAIL press_valid: got v%b h%b c%0d want v1 h1 c9",
               key_valid, key_held, key_code);
    end
    tick(1);
    nvec++;
    if (key_valid !== 1'b0) begin
      nerr++;
      $display("FAIL press_pulse_len: got %b want 0", key_valid);
    end
    nv = 0;
    nh = 0;
    for (int i = 0; i < 96; i++) begin
      tick(1);
      if (key_valid || key_release || multi_key) nv++;
      if (!key_held) nh++;
    end
    nvec++;
    if (nv !== 0 || nh !== 0) begin
      nerr++;
      $display("FAIL press_hold: got %0d pulses %0d drops want 0 0",
               nv, nh);
    end
  endtask

  task automatic test_release;
    int nr;
    keys = '0;
    nr = 0;
    for (int i = 0; i < 94; i++) begin
      tick(1);
      if (key_release || key_valid) nr++;
    end
    nvec++;
    if (nr !== 0 || key_held !== 1'b1) begin
      nerr++;
      $display("FAIL rel_early: got %0d pulses held %b want 0 1",
               nr, key_held);
    end
    tick(1);
    nvec++;
    if ({key_release, key_held, key_code} !== {2'b10, 4'd9}) begin
      nerr++;
      $display("FAIL rel_pulse: got r%b h%b c%0d want r1 h0 c9",
               key_release, key_held, key_code);
    end
    tick(1);
    nvec++;
    if (key_release !== 1'b0) begin
      nerr++;
      $display("FAIL rel_pulse_len: got %b want 0", key_release);
    end
  endtask

  task automatic test_bounce;
    int nv;
    do_reset(16'h0001);
    nv = 0;
    for (int f = 0; f < 6; f++) begin
      keys = (f % 2 == 0) ? 16'h0001 : 16'h0000;
      for (int i = 0; i < 32; i++) begin
        tick(1);
        if (key_valid || key_held) nv++;
      end
    end
    nvec++;
    if (nv !== 0) begin
      nerr++;
      $display("FAIL bounce_quiet: got %0d cycles active want 0", nv);
    end
    keys = 16'h0001;
    nv = 0;
    for (int i = 0; i < 95; i++) begin
      tick(1);
      if (key_valid) nv++;
    end
    nvec++;
    if (nv !== 0) begin
      nerr++;
      $display("FAIL bounce_early: got %0d pulses want 0", nv);
    end
    tick(1);
    nvec++;
    if ({key_valid, key_held, key_code} !== {2'b11, 4'd0}) begin
      nerr++;
      $display("FAIL bounce_valid: got v%b h%b c%0d want v1 h1 c0",
               key_valid, key_held, key_code);
    end
  endtask

  task automatic test_multi_key;
    int nm;
    int nv;
    do_reset(16'h0021);
    for (int f = 1; f <= 3; f++) begin
      nm = 0;
      nv = 0;
      for (int i = 0; i < 31; i++) begin
        tick(1);
        if (multi_key) nm++;
        if (key_valid) nv++;
      end
      tick(1);
      nvec++;
      if (multi_key !== 1'b1 || key_valid !== 1'b0 ||
          nm !== 0 || nv !== 0) begin
        nerr++;
        $display("FAIL multi_f%0d: got m%b v%b nm%0d nv%0d want m1 v0 0 0",
                 f, multi_key, key_valid, nm, nv);
      end
    end
    keys = 16'h0001;
    nm = 0;
    nv = 0;
    for (int i = 0; i < 95; i++) begin
      tick(1);
      if (multi_key) nm++;
      if (key_valid) nv++;
    end
    nvec++;
    if (nm !== 0 || nv !== 0) begin
      nerr++;
      $display("FAIL multi_rel1: got nm%0d nv%0d want 0 0", nm, nv);
    end
    tick(1);
    nvec++;
    if ({key_valid, key_held, key_code} !== {2'b11, 4'd0}) begin
      nerr++;
      $display("FAIL multi_valid: got v%b h%b c%0d want v1 h1 c0",
               key_valid, key_held, key_code);
    end
    tick(1);
  endtask

  task automatic test_async_reset;
    int np;
    tick(8);
    nvec++;
    if (key_held !== 1'b1 || col !== 4'b1101) begin
      nerr++;
      $display("FAIL arst_pre: got h%b col %b want h1 col 1101",
               key_held, col);
    end
    #2;
    rst_n = 1'b0;
    #1;
    nvec++;
    if (key_held !== 1'b0 || col !== 4'b1110) begin
      nerr++;
      $display("FAIL arst_now: got h%b col %b want h0 col 1110",
               key_held, col);
    end
    keys = '0;
    np = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (key_release || key_valid || key_held) np++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 128; i++) begin
      tick(1);
      if (key_release || key_valid || key_held) np++;
    end
    nvec++;
    if (np !== 0) begin
      nerr++;
      $display("FAIL arst_quiet: got %0d active cycles want 0", np);
    end
  endtask

  initial begin
    nvec  = 0;
    nerr  = 0;
    rst_n = 1'b0;
    keys  = '0;
    test_reset();
    test_single_press();
    test_release();
    test_bounce();
    test_multi_key();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
